// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back scheduler: queued FP result entry,
// grant encoding and the scoreboard mask helper.
package wb_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_AW     = 5;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [DEF_REG_AW-1:0] rd;
    logic                  dbl;
    logic [DEF_DATA_W-1:0] data_0;
    logic [DEF_DATA_W-1:0] data_1;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_INT,
    GNT_FP
  } grant_t;

  // Register pair indices wrap 31 -> 0, so the high half of a double at r31 is r0.
  function automatic logic [31:0] reg_mask(input logic [DEF_REG_AW-1:0] rd,
                                           input logic                  dbl);
    logic [DEF_REG_AW-1:0] hi;
    logic [31:0]           m;
    hi = rd + DEF_REG_AW'(1);
    m  = 32'(1) << rd;
    if (dbl) m = m | (32'(1) << hi);
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of queued FP write-back entries; pointers wrap modulo DEPTH
// (power of two), occupancy tracked in an explicit counter.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t wdata,
  output wb_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates integer results against queued FP results
// and keeps the FP pending scoreboard. Optional decode bypass outputs under WB_FWD_EN.
module reg_wb_scheduler
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_AW     = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              int_valid,
  output logic              int_ready,
  input  logic [REG_AW-1:0] int_rd,
  input  logic [DATA_W-1:0] int_data,
  input  logic              fp_valid,
  output logic              fp_ready,
  input  logic [REG_AW-1:0] fp_rd,
  input  logic              fp_double,
  input  logic [DATA_W-1:0] fp_data_0,
  input  logic [DATA_W-1:0] fp_data_1,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_double,
  output logic [31:0]       busy_q,
  output logic              RegWrite,
  output logic              Fp,
  output logic              double,
  output logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] write_data_0,
  output logic [DATA_W-1:0] write_data_1
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic              fwd_fp,
  output logic              fwd_double,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data_0,
  output logic [DATA_W-1:0] fwd_data_1
`endif
);

  wb_entry_t         push_entry;
  wb_entry_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  grant_t            gnt;
  logic              g_fp;
  logic              g_dbl;
  logic [REG_AW-1:0] g_reg;
  logic [DATA_W-1:0] g_d0;
  logic [DATA_W-1:0] g_d1;
  logic [31:0]       set_mask;
  logic [31:0]       clr_mask;

  // Both readies depend only on registered FIFO occupancy.
  assign fp_ready  = ~fifo_full;
  assign int_ready = ~fifo_full;

  assign push_entry.rd     = fp_rd;
  assign push_entry.dbl    = fp_double;
  assign push_entry.data_0 = fp_data_0;
  assign push_entry.data_1 = fp_data_1;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fp_valid),
    .pop   (gnt == GNT_FP),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A full queue must drain first, otherwise integer results take priority.
  always_comb begin
    gnt = GNT_NONE;
    if (fifo_full)       gnt = GNT_FP;
    else if (int_valid)  gnt = GNT_INT;
    else if (!fifo_empty) gnt = GNT_FP;
  end

  always_comb begin
    g_fp  = 1'b0;
    g_dbl = 1'b0;
    g_reg = int_rd;
    g_d0  = int_data;
    g_d1  = '0;
    if (gnt == GNT_FP) begin
      g_fp  = 1'b1;
      g_dbl = head.dbl;
      g_reg = head.rd;
      g_d0  = head.data_0;
      g_d1  = head.data_1;
    end
  end

  assign set_mask = issue_valid ? reg_mask(issue_rd, issue_double) : '0;
  assign clr_mask = (gnt == GNT_FP) ? reg_mask(head.rd, head.dbl) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q       <= '0;
      RegWrite     <= 1'b0;
      Fp           <= 1'b0;
      double       <= 1'b0;
      write_reg    <= '0;
      write_data_0 <= '0;
      write_data_1 <= '0;
    end else begin
      // An issue landing on a bit being retired this cycle keeps it pending.
      busy_q   <= (busy_q & ~clr_mask) | set_mask;
      RegWrite <= (gnt != GNT_NONE);
      if (gnt != GNT_NONE) begin
        Fp           <= g_fp;
        double       <= g_dbl;
        write_reg    <= g_reg;
        write_data_0 <= g_d0;
        write_data_1 <= g_d1;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid  = rst_n & (gnt != GNT_NONE);
  assign fwd_fp     = g_fp;
  assign fwd_double = g_dbl;
  assign fwd_reg    = g_reg;
  assign fwd_data_0 = g_d0;
  assign fwd_data_1 = g_d1;
`endif

endmodule
